// File: rtl/eprisc_pkg.sv
// Shared epRISC definitions: default fetch widths, the NOP encoding and the
// fetch FSM state encoding.
package eprisc_pkg;

  localparam int EPRISC_ADDR_W = 12;
  localparam int EPRISC_DATA_W = 32;
  localparam logic [31:0] EPRISC_NOP = 32'h0400_0000;

  typedef enum logic {
    FETCH_RUN    = 1'b0,
    FETCH_HALTED = 1'b1
  } fetchState_t;

endpackage

// File: rtl/eprisc_fetch_if.sv
// Fetch-stage bus bundle: boot ROM port, decode handshake and the
// redirect/halt controls. The fetch unit takes the master modport; the
// surrounding core (ROM + decode) takes the slave modport.
interface eprisc_fetch_if
  import eprisc_pkg::*;
#(
  parameter int ADDR_W = EPRISC_ADDR_W,
  parameter int DATA_W = EPRISC_DATA_W
);

  logic [ADDR_W-1:0] oRomAddr;
  logic              oRomEnable;
  logic [DATA_W-1:0] iRomData;
  logic              iRedirect;
  logic [ADDR_W-1:0] iRedirectPc;
  logic              iHalt;
  logic [DATA_W-1:0] oInstr;
  logic [ADDR_W-1:0] oInstrPc;
  logic              oValid;
  logic              iReady;
  logic              oBusy;

  modport master (
    output oRomAddr, oRomEnable, oInstr, oInstrPc, oValid, oBusy,
    input  iRomData, iRedirect, iRedirectPc, iHalt, iReady
  );

  modport slave (
    input  oRomAddr, oRomEnable, oInstr, oInstrPc, oValid, oBusy,
    output iRomData, iRedirect, iRedirectPc, iHalt, iReady
  );

endinterface

// File: rtl/eprisc_fetch_fifo.sv
// Small synchronous FIFO holding {pc, instr} prefetch entries.
// DEPTH must be a power of two so the pointers wrap for free.
// Simultaneous push and pop on a full FIFO is allowed; flush wins over both.
module eprisc_fetch_fifo #(
  parameter int WIDTH = 44,
  parameter int DEPTH = 2,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             iClk,
  input  logic             iRst_n,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] pushData,
  output logic [CNT_W-1:0] count,
  output logic [WIDTH-1:0] head
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rdPtr;
  logic [PTR_W-1:0] wrPtr;
  logic             doPush;
  logic             doPop;

  assign doPop  = pop && (count != '0);
  assign doPush = push && ((count != CNT_W'(DEPTH)) || doPop);
  assign head   = mem[rdPtr];

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
    end else if (flush) begin
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + 1'b1;
      if (doPop)  rdPtr <= rdPtr + 1'b1;
      count <= count + CNT_W'(doPush) - CNT_W'(doPop);
    end
  end

  // Entry storage; contents are only meaningful below count, so no reset.
  always_ff @(posedge iClk) begin
    if (doPush && !flush) mem[wrPtr] <= pushData;
  end

endmodule

// File: rtl/eprisc_fetch_unit.sv
// epRISC instruction fetch stage: owns the PC, issues one-cycle-latency
// boot ROM reads under a credit rule so the prefetch FIFO can never
// overflow, and presents words to decode over valid/ready.
// Optional performance counters: define EPRISC_FETCH_PERFCNT_EN.
//
// state        | meaning
// FETCH_RUN    | issuing fetches whenever credit allows
// FETCH_HALTED | iHalt high: no new issues, in-flight word and FIFO still drain
module eprisc_fetch_unit
  import eprisc_pkg::*;
#(
  parameter int              ADDR_W   = EPRISC_ADDR_W,
  parameter int              DATA_W   = EPRISC_DATA_W,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int              FIFO_DEP = 2
) (
  input  logic          iClk,
  input  logic          iRst_n,
  eprisc_fetch_if.master fetchBus
`ifdef EPRISC_FETCH_PERFCNT_EN
  ,
  output logic [31:0]   oFetchCnt,
  output logic [31:0]   oStallCnt
`endif
);

  localparam int CNT_W = $clog2(FIFO_DEP) + 1;
  localparam int CRD_W = CNT_W + 1;
  localparam int ENT_W = ADDR_W + DATA_W;

  fetchState_t       state;
  fetchState_t       stateNext;
  logic              canIssue;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] inflightPc;
  logic              inflight;
  logic              killReturn;
  logic              issue;
  logic              push;
  logic              pop;
  logic              valid;
  logic [CNT_W-1:0]  count;
  logic [ENT_W-1:0]  head;
  logic [CRD_W-1:0]  credit;

  // A redirect kills the word returning this cycle; nothing else is ever in flight.
  assign killReturn = fetchBus.iRedirect;
  assign valid      = (count != '0);
  assign pop        = valid && fetchBus.iReady;
  assign push       = inflight && !killReturn;
  // Occupancy after this edge's pop and landing word; a new issue needs a free slot beyond it.
  assign credit     = CRD_W'(count) + CRD_W'(inflight) - CRD_W'(pop);
  assign issue      = canIssue && !fetchBus.iRedirect && (credit < CRD_W'(FIFO_DEP));

  // Next-state and issue permission from the halt input.
  always_comb begin
    stateNext = state;
    canIssue  = 1'b0;
    case (state)
      FETCH_RUN: begin
        if (fetchBus.iHalt) stateNext = FETCH_HALTED;
        else                canIssue  = 1'b1;
      end
      FETCH_HALTED: begin
        if (!fetchBus.iHalt) begin
          stateNext = FETCH_RUN;
          canIssue  = 1'b1;
        end
      end
      default: stateNext = FETCH_RUN;
    endcase
  end

  // State register, PC and in-flight tracking.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state      <= FETCH_RUN;
      pc         <= RESET_PC;
      inflight   <= 1'b0;
      inflightPc <= RESET_PC;
    end else begin
      state    <= stateNext;
      inflight <= issue;
      if (issue) inflightPc <= pc;
      if (fetchBus.iRedirect) pc <= fetchBus.iRedirectPc;
      else if (issue)         pc <= pc + 1'b1;
    end
  end

  eprisc_fetch_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (FIFO_DEP)
  ) u_fifo (
    .iClk     (iClk),
    .iRst_n   (iRst_n),
    .push     (push),
    .pop      (pop),
    .flush    (fetchBus.iRedirect),
    .pushData ({inflightPc, fetchBus.iRomData}),
    .count    (count),
    .head     (head)
  );

  assign fetchBus.oRomAddr   = pc;
  assign fetchBus.oRomEnable = inflight;
  assign fetchBus.oValid     = valid;
  assign fetchBus.oInstr     = valid ? head[DATA_W-1:0] : DATA_W'(EPRISC_NOP);
  assign fetchBus.oInstrPc   = valid ? head[ENT_W-1:DATA_W] : RESET_PC;
  assign fetchBus.oBusy      = inflight || valid;

`ifdef EPRISC_FETCH_PERFCNT_EN
  // Saturating issue and stall counters.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      oFetchCnt <= '0;
      oStallCnt <= '0;
    end else begin
      if (issue && (oFetchCnt != '1)) oFetchCnt <= oFetchCnt + 1'b1;
      if (!valid && !fetchBus.iHalt && (oStallCnt != '1)) oStallCnt <= oStallCnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_eprisc_fetch_unit.sv
// Self-checking bench for eprisc_fetch_unit: queue-based reference model,
// directed scenarios with literal expectations, then randomized traffic.
module tb_eprisc_fetch_unit;
  import eprisc_pkg::*;

  localparam int AW  = 12;
  localparam int DW  = 32;
  localparam int DEP = 2;

  logic iClk   = 1'b0;
  logic iRst_n = 1'b0;

  eprisc_fetch_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

`ifdef EPRISC_FETCH_PERFCNT_EN
  logic [31:0] oFetchCnt;
  logic [31:0] oStallCnt;
`endif

  eprisc_fetch_unit #(
    .ADDR_W   (AW),
    .DATA_W   (DW),
    .RESET_PC (12'h000),
    .FIFO_DEP (DEP)
  ) dut (
    .iClk     (iClk),
    .iRst_n   (iRst_n),
    .fetchBus (bus)
`ifdef EPRISC_FETCH_PERFCNT_EN
    ,
    .oFetchCnt (oFetchCnt),
    .oStallCnt (oStallCnt)
`endif
  );

  always #5 iClk = ~iClk;

  // Boot ROM: contents addr+0x100, one-cycle registered read, junk when not enabled.
  function automatic logic [DW-1:0] romWord(input logic [AW-1:0] a);
    return 32'h100 + 32'(a);
  endfunction

  logic [DW-1:0] romReg;
  always @(posedge iClk) romReg <= romWord(bus.oRomAddr);
  assign bus.iRomData = bus.oRomEnable ? romReg : 32'hBADB_AD00;

  // Reference model: what decode should see, as a queue of {pc, instr}.
  typedef struct packed {
    logic [AW-1:0] pc;
    logic [DW-1:0] instr;
  } ent_t;

  ent_t          mQ[$];
  bit            mInflight   = 1'b0;
  logic [AW-1:0] mInflightPc = '0;
  logic [AW-1:0] mPc         = '0;
  longint        mFetch      = 0;
  longint        mStall      = 0;

  always @(posedge iClk or negedge iRst_n) begin : model
    int occ;
    bit doPop;
    bit doIssue;
    if (!iRst_n) begin
      mQ.delete();
      mInflight = 1'b0;
      mPc       = '0;
      mFetch    = 0;
      mStall    = 0;
    end else begin
      if (mQ.size() == 0 && !bus.iHalt) mStall++;
      if (bus.iRedirect) begin
        mQ.delete();
        mInflight = 1'b0;
        mPc       = bus.iRedirectPc;
      end else begin
        doPop   = (mQ.size() > 0) && bus.iReady;
        occ     = mQ.size() - int'(doPop) + int'(mInflight);
        doIssue = !bus.iHalt && (occ < DEP);
        if (doPop) void'(mQ.pop_front());
        if (mInflight) mQ.push_back(ent_t'{pc: mInflightPc, instr: romWord(mInflightPc)});
        assert (!(mQ.size() == DEP && doIssue)) else $error("model: full FIFO with word in flight");
        mInflight = doIssue;
        if (doIssue) begin
          mInflightPc = mPc;
          mPc         = mPc + 1'b1;
          mFetch++;
        end
      end
    end
  end

  int nTests = 0;
  int nFail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nTests++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] sat32(input longint v);
    return (v > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : v[31:0];
  endfunction

  // Compare process: DUT outputs against the model every cycle, away from the active edge.
  always @(negedge iClk) begin
    chk("m_valid", 64'(bus.oValid), 64'(mQ.size() > 0));
    if (mQ.size() > 0) begin
      chk("m_instr", 64'(bus.oInstr), 64'(mQ[0].instr));
      chk("m_instrPc", 64'(bus.oInstrPc), 64'(mQ[0].pc));
    end
    chk("m_romAddr", 64'(bus.oRomAddr), 64'(mPc));
    chk("m_romEnable", 64'(bus.oRomEnable), 64'(mInflight));
    chk("m_busy", 64'(bus.oBusy), 64'(mInflight || (mQ.size() > 0)));
`ifdef EPRISC_FETCH_PERFCNT_EN
    chk("m_fetchCnt", 64'(oFetchCnt), 64'(sat32(mFetch)));
    chk("m_stallCnt", 64'(oStallCnt), 64'(sat32(mStall)));
`endif
  end

  task automatic step(input int n = 1);
    repeat (n) @(negedge iClk);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [AW-1:0] a;
    logic [AW-1:0] n;
    bit            hold;
    bus.iReady      = 1'b1;
    bus.iHalt       = 1'b0;
    bus.iRedirect   = 1'b0;
    bus.iRedirectPc = '0;

    // Reset values.
    step(2);
    chk("rst_valid", 64'(bus.oValid), 64'h0);
    chk("rst_instr", 64'(bus.oInstr), 64'h0400_0000);
    chk("rst_instrPc", 64'(bus.oInstrPc), 64'h0);
    chk("rst_busy", 64'(bus.oBusy), 64'h0);
    chk("rst_romEnable", 64'(bus.oRomEnable), 64'h0);
    chk("rst_romAddr", 64'(bus.oRomAddr), 64'h0);

    // Startup: first word visible two edges after release.
    iRst_n = 1'b1;
    step();
    chk("st_romAddr1", 64'(bus.oRomAddr), 64'h1);
    chk("st_romEnable", 64'(bus.oRomEnable), 64'h1);
    chk("st_valid0", 64'(bus.oValid), 64'h0);
    step();
    chk("st_valid1", 64'(bus.oValid), 64'h1);
    chk("st_instr0", 64'(bus.oInstr), 64'h100);
    chk("st_pc0", 64'(bus.oInstrPc), 64'h0);
    step();
    chk("st_pc1", 64'(bus.oInstrPc), 64'h1);
    chk("st_instr1", 64'(bus.oInstr), 64'h101);

    // Backpressure: FIFO fills with words 1,2 and issue stalls at pc 3.
    bus.iReady = 1'b0;
    step(6);
    chk("bp_romAddr", 64'(bus.oRomAddr), 64'h3);
    chk("bp_romEnable", 64'(bus.oRomEnable), 64'h0);
    chk("bp_headPc", 64'(bus.oInstrPc), 64'h1);
    chk("bp_busy", 64'(bus.oBusy), 64'h1);
    bus.iReady = 1'b1;
    step();
    chk("bp_rel_pc2", 64'(bus.oInstrPc), 64'h2);
    step();
    chk("bp_rel_pc3", 64'(bus.oInstrPc), 64'h3);

    // Redirect to 0x028 while 0x005 is in flight.
    for (int i = 0; i < 20 && !(bus.oRomAddr == 12'h006 && bus.oRomEnable); i++) step();
    chk("rd_reach5", 64'(bus.oRomAddr == 12'h006 && bus.oRomEnable), 64'h1);
    bus.iRedirect   = 1'b1;
    bus.iRedirectPc = 12'h028;
    step();
    bus.iRedirect = 1'b0;
    chk("rd_flush", 64'(bus.oValid), 64'h0);
    chk("rd_pc", 64'(bus.oRomAddr), 64'h028);
    chk("rd_noIssue", 64'(bus.oRomEnable), 64'h0);
    step();
    chk("rd_valid_e1", 64'(bus.oValid), 64'h0);
    step();
    chk("rd_valid_e2", 64'(bus.oValid), 64'h1);
    chk("rd_target", 64'(bus.oInstrPc), 64'h028);
    chk("rd_instr", 64'(bus.oInstr), 64'h128);

    // PC wrap through 0xFFF.
    bus.iRedirect   = 1'b1;
    bus.iRedirectPc = 12'hFFE;
    step();
    bus.iRedirect = 1'b0;
    step(2);
    chk("wr_ffe", 64'(bus.oInstrPc), 64'hFFE);
    chk("wr_ffe_instr", 64'(bus.oInstr), 64'h10FE);
    step();
    chk("wr_fff", 64'(bus.oInstrPc), 64'hFFF);
    step();
    chk("wr_000", 64'(bus.oInstrPc), 64'h000);
    step();
    chk("wr_001", 64'(bus.oInstrPc), 64'h001);

    // Halt for 4 cycles mid-stream.
    a = bus.oRomAddr;
    n = bus.oInstrPc;
    bus.iHalt = 1'b1;
    step();
    chk("ht_landed", 64'(bus.oInstrPc), 64'(n + 1'b1));
    chk("ht_noIssue", 64'(bus.oRomEnable), 64'h0);
    step();
    chk("ht_drained", 64'(bus.oValid), 64'h0);
    step(2);
    chk("ht_romAddr", 64'(bus.oRomAddr), 64'(a));
    chk("ht_busy", 64'(bus.oBusy), 64'h0);
    bus.iHalt = 1'b0;
    step();
    chk("ht_resume", 64'(bus.oRomAddr), 64'(a + 1'b1));
    step();
    chk("ht_resumePc", 64'(bus.oInstrPc), 64'(a));

    // Redirect during halt loads pc but does not fetch.
    bus.iHalt       = 1'b1;
    bus.iRedirect   = 1'b1;
    bus.iRedirectPc = 12'h200;
    step();
    bus.iRedirect = 1'b0;
    step(2);
    chk("hr_pc", 64'(bus.oRomAddr), 64'h200);
    chk("hr_noFetch", 64'(bus.oBusy), 64'h0);
    bus.iHalt = 1'b0;
    step(2);
    chk("hr_target", 64'(bus.oInstrPc), 64'h200);

    // Randomized traffic; the compare process checks every cycle.
    hold = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      bus.iReady = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 15) == 0) hold = ~hold;
      bus.iHalt     = hold;
      bus.iRedirect = ($urandom_range(0, 19) == 0);
      bus.iRedirectPc = ($urandom_range(0, 3) == 0) ? 12'hFFC + 12'($urandom_range(0, 3))
                                                    : 12'($urandom);
      step();
    end

    // Asynchronous reset mid-stream with a valid head.
    bus.iHalt     = 1'b0;
    bus.iRedirect = 1'b0;
    bus.iReady    = 1'b0;
    for (int i = 0; i < 10 && !bus.oValid; i++) step();
    chk("ar_validBefore", 64'(bus.oValid), 64'h1);
    #2;
    iRst_n = 1'b0;
    #1;
    chk("ar_valid", 64'(bus.oValid), 64'h0);
    chk("ar_busy", 64'(bus.oBusy), 64'h0);
    chk("ar_romEnable", 64'(bus.oRomEnable), 64'h0);
    chk("ar_romAddr", 64'(bus.oRomAddr), 64'h0);
`ifdef EPRISC_FETCH_PERFCNT_EN
    chk("ar_fetchCnt", 64'(oFetchCnt), 64'h0);
    chk("ar_stallCnt", 64'(oStallCnt), 64'h0);
`endif
    step(2);
    iRst_n     = 1'b1;
    bus.iReady = 1'b1;
    step(2);
    chk("ar_restartPc", 64'(bus.oInstrPc), 64'h0);
    chk("ar_restartInstr", 64'(bus.oInstr), 64'h100);
    step(20);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
